// File: rtl/simple_uart_rx.sv
// 8E1 UART receiver: 2-FF synchronizer, mid-bit sampling, even-parity and
// stop-bit checking with a one-cycle valid strobe per completed frame.
module simple_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  state_t        state, next_state;
  logic          sync_ff, sline, sline_prev;
  logic [TW-1:0] timer, next_timer;
  logic [2:0]    idx, next_idx;
  logic [7:0]    shreg, next_shreg;
  logic          par_bit, next_par;
  logic          done, stop_bit, tick;

  // Next-state, bit-timer and shift-register logic; sampling happens when the timer reaches zero
  always_comb begin
    next_state = state;
    next_timer = timer;
    next_idx   = idx;
    next_shreg = shreg;
    next_par   = par_bit;
    done       = 1'b0;
    stop_bit   = 1'b1;
    tick       = (timer == {TW{1'b0}});
    case (state)
      IDLE: begin
        // Falling edge only, so a line held low never re-triggers
        if (!sline && sline_prev) begin
          next_state = START;
          next_timer = HALF_LOAD;
        end else begin
          next_timer = {TW{1'b0}};
        end
      end
      START: begin
        if (tick) begin
          next_timer = FULL_LOAD;
          next_idx   = 3'd0;
          if (sline) begin
            next_state = IDLE;
          end else begin
            next_state = DATA;
          end
        end else begin
          next_timer = timer - TW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          next_timer = FULL_LOAD;
          next_shreg = {sline, shreg[7:1]};
          next_idx   = idx + 3'd1;
          if (idx == 3'd7) begin
            next_state = PARITY;
          end else begin
            next_state = DATA;
          end
        end else begin
          next_timer = timer - TW'(1);
        end
      end
      PARITY: begin
        if (tick) begin
          next_timer = FULL_LOAD;
          next_par   = sline;
          next_state = STOP;
        end else begin
          next_timer = timer - TW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          done     = 1'b1;
          stop_bit = sline;
          if (sline) begin
            next_state = IDLE;
          end else begin
            next_state = WAIT_HIGH;
          end
        end else begin
          next_timer = timer - TW'(1);
        end
      end
      WAIT_HIGH: begin
        if (sline) begin
          next_state = IDLE;
        end else begin
          next_state = WAIT_HIGH;
        end
      end
      default: begin
        next_state = IDLE;
        next_timer = {TW{1'b0}};
      end
    endcase
  end

  // Synchronizer, state register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff    <= 1'b1;
      sline      <= 1'b1;
      sline_prev <= 1'b1;
      state      <= IDLE;
      timer      <= {TW{1'b0}};
      idx        <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
    end else begin
      sync_ff    <= line;
      sline      <= sync_ff;
      sline_prev <= sline;
      state      <= next_state;
      timer      <= next_timer;
      idx        <= next_idx;
      shreg      <= next_shreg;
      par_bit    <= next_par;
    end
  end

  // Registered outputs, updated one cycle after the stop-bit sample
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= 8'h00;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= done;
      busy  <= (next_state != IDLE);
      if (done) begin
        data       <= shreg;
        parity_err <= (par_bit != even_parity(shreg));
        frame_err  <= ~stop_bit;
      end
    end
  end

endmodule

// File: tb/tb_simple_uart_rx.sv
// Directed self-checking bench for simple_uart_rx at CLKS_PER_BIT=16.
module tb_simple_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line = 1'b1;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, busy;

  int         ntests = 0;
  int         nfail = 0;
  int         cyc = 0;
  int         vcount = 0;
  logic [7:0] vdata [0:15];
  logic       vperr [0:15];
  logic       vferr [0:15];
  int         vcyc  [0:15];

  simple_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .line(line), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Valid-pulse monitor: records the payload of every pulse
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid && vcount < 16) begin
      vdata[vcount] <= data;
      vperr[vcount] <= parity_err;
      vferr[vcount] <= frame_err;
      vcyc[vcount]  <= cyc;
    end
    if (valid) vcount <= vcount + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    line = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(s);
  endtask

  initial begin
    // Reset state
    idle(4);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle(20);

    // 0xA5, correct parity (0), good stop
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(5);
    check("a5_count", vcount, 1);
    check("a5_data", vdata[0], 8'hA5);
    check("a5_perr", vperr[0], 1'b0);
    check("a5_ferr", vferr[0], 1'b0);
    check("a5_busy", busy, 1'b0);

    // 0x01 with wrong parity
    send_frame(8'h01, 1'b0, 1'b1);
    idle(5);
    check("p01_count", vcount, 2);
    check("p01_data", vdata[1], 8'h01);
    check("p01_perr", vperr[1], 1'b1);
    check("p01_ferr", vferr[1], 1'b0);

    // 0x3C with stop bit low, then a long break
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(40 * CPB - CPB);
    check("brk_busy", busy, 1'b1);
    check("brk_count", vcount, 3);
    check("brk_data", vdata[2], 8'h3C);
    check("brk_ferr", vferr[2], 1'b1);
    check("brk_perr", vperr[2], 1'b0);
    line = 1'b1;
    idle(10);
    check("brk_idle", busy, 1'b0);
    check("brk_novalid", vcount, 3);

    // Short glitch from idle must be rejected with flags untouched
    idle(20);
    line = 1'b0;
    idle(4);
    line = 1'b1;
    idle(40);
    check("gl_count", vcount, 3);
    check("gl_busy", busy, 1'b0);
    check("gl_ferr", frame_err, 1'b1);
    check("gl_data", data, 8'h3C);

    // Back-to-back frames, no idle gap
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    idle(5);
    check("b2b_count", vcount, 5);
    check("b2b_d0", vdata[3], 8'h55);
    check("b2b_d1", vdata[4], 8'hAA);
    check("b2b_gap", vcyc[4] - vcyc[3], 11 * CPB);
    check("b2b_err", {vperr[3], vferr[3], vperr[4], vferr[4]}, 4'b0000);

    // Reset during the DATA state
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    idle(3);
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_flags", {valid, parity_err, frame_err, busy}, 4'b0000);
    line = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(12 * CPB);
    check("mid_rst_novalid", vcount, 5);
    check("mid_rst_idle", busy, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b1);
    idle(5);
    check("f0f_count", vcount, 6);
    check("f0f_data", vdata[5], 8'h0F);
    check("f0f_err", {vperr[5], vferr[5]}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/simple_uart_rx.md
SIMPLE_UART_RX -- requirements
Module: simple_uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 4..4095.
REQ-002 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: line  input  1  asynchronous serial input; idle high.
REQ-005 Port: data  output  8  last received byte.
REQ-006 Port: valid  output  1  one-cycle pulse; frame complete, data/flags updated.
REQ-007 Port: parity_err  output  1  last frame failed even-parity check.
REQ-008 Port: frame_err  output  1  last frame's stop bit sampled low.
REQ-009 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-010 Frame format SHALL be: start (0), d0..d7 LSB first, parity, stop (1); 11 bit periods.
REQ-011 Parity SHALL be even: expected parity bit = XOR of d0..d7.
REQ-012 line SHALL pass through a 2-FF synchronizer; only the synchronized value (sline) is used.
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-014 IDLE: on sline=0, go to START and load the bit-timer so the next sample falls CLKS_PER_BIT/2 (integer division) cycles later.
REQ-015 START sample: sline=1 is a glitch and SHALL return to IDLE with no valid and no flag change; sline=0 goes to DATA.
REQ-016 Each later sample SHALL occur exactly CLKS_PER_BIT cycles after the previous one.
REQ-017 DATA SHALL shift 8 samples into the byte LSB first using a 3-bit index, then go to PARITY.
REQ-018 PARITY SHALL capture one sample, then go to STOP.
REQ-019 In the cycle after the stop sample: data<=byte, parity_err<=(parity sample != ^byte), frame_err<=(stop sample==0), and valid=1.
REQ-020 From STOP: stop=1 goes to IDLE; stop=0 goes to WAIT_HIGH.
REQ-021 WAIT_HIGH SHALL hold until sline=1, then go to IDLE; this prevents re-triggering on a break condition.
REQ-022 valid SHALL be high for exactly one cycle per completed frame; no valid for glitch-rejected starts.
REQ-023 data, parity_err and frame_err SHALL hold their values until the next valid.
REQ-024 A falling edge seen in the cycle IDLE is re-entered SHALL start a new frame; back-to-back frames with no idle gap are supported.
REQ-025 Transitions on line during bit periods other than the sample cycle SHALL have no effect.
REQ-026 The bit-timer width SHALL be ceil(log2(CLKS_PER_BIT)) bits; no wrap-around is permitted within a bit period.

Reset
REQ-027 rst=1 SHALL force state IDLE, data=0x00, valid=0, parity_err=0, frame_err=0, busy=0, and synchronizer flops to 1.
REQ-028 rst asserted mid-frame SHALL abort the frame with no valid; after release the receiver SHALL wait for a fresh falling edge.
REQ-029 rst SHALL take priority over every other event in the same cycle.

Verification (CLKS_PER_BIT=16)
REQ-030 Send 0xA5 with parity 0 and stop 1 -> one valid pulse, data=0xA5, parity_err=0, frame_err=0, busy low after the stop sample.
REQ-031 Send 0x01 with parity 0 (wrong) -> valid, data=0x01, parity_err=1, frame_err=0.
REQ-032 Send 0x3C with correct parity and stop bit 0, then hold line low 40 bit periods -> one valid with frame_err=1, busy high until line returns high, no second valid.
REQ-033 Pulse line low for 4 cycles from idle -> no valid, returns to IDLE, flags unchanged.
REQ-034 Send 0x55 then 0xAA back-to-back with no idle gap -> two valid pulses 11x16 cycles apart carrying 0x55 then 0xAA, no errors.
REQ-035 Assert rst during the DATA state of a frame -> no valid, all outputs at reset values; a following 0x0F frame is received correctly.
